// File: rtl/hm01b0_sim.sv
// Behavioural HM01B0 sensor model: replays hm01b0_image as a free-running
// 8-bit QVGA stream with pixel clock, line-valid (hsync) and frame-valid (vsync).
module hm01b0_sim #(
  parameter int WIDTH         = 320,
  parameter int HEIGHT        = 240,
  parameter int H_BLANK       = 16,
  parameter int V_FRONT       = 8,
  parameter int V_BLANK_LINES = 20
) (
  input  logic       mclk,
  input  logic       nreset,
  output logic       clock,
  output logic [7:0] pixdata,
  output logic       hsync,
  output logic       vsync
);

  localparam int DEPTH    = WIDTH * HEIGHT;
  localparam int LINE_CYC = WIDTH + H_BLANK;
  localparam int VB_CYC   = V_BLANK_LINES * LINE_CYC;
  localparam int MAX_CNT  = (V_FRONT > VB_CYC) ? V_FRONT : VB_CYC;
  localparam int CNT_W    = $clog2(MAX_CNT + 1);
  localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COL_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {FRONT, LINE, HBLANK, VBLANK} state_t;

  // Loaded from outside by hierarchical reference; unloaded words stay X.
  logic [7:0] hm01b0_image [0:DEPTH-1];

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] addr;

  // Consumers sample on the rising edge of clock, i.e. mid-way through each mclk cycle.
  assign clock = nreset & ~mclk;

  always_ff @(posedge mclk or negedge nreset) begin
    if (!nreset) begin
      state   <= FRONT;
      cnt     <= '0;
      col     <= '0;
      row     <= '0;
      addr    <= '0;
      hsync   <= 1'b0;
      vsync   <= 1'b0;
      pixdata <= 8'd0;
    end else begin
      case (state)
        FRONT: begin
          vsync   <= 1'b1;
          hsync   <= 1'b0;
          pixdata <= 8'd0;
          if (cnt == CNT_W'(V_FRONT - 1)) begin
            cnt   <= '0;
            col   <= '0;
            row   <= '0;
            addr  <= '0;
            state <= LINE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        LINE: begin
          vsync   <= 1'b1;
          hsync   <= 1'b1;
          pixdata <= hm01b0_image[addr];
          addr    <= addr + ADDR_W'(1);
          if (col == COL_W'(WIDTH - 1)) begin
            col   <= '0;
            cnt   <= '0;
            state <= HBLANK;
          end else begin
            col <= col + COL_W'(1);
          end
        end
        HBLANK: begin
          vsync   <= 1'b1;
          hsync   <= 1'b0;
          pixdata <= 8'd0;
          if (cnt == CNT_W'(H_BLANK - 1)) begin
            cnt <= '0;
            if (row == ROW_W'(HEIGHT - 1)) begin
              state <= VBLANK;
            end else begin
              row   <= row + ROW_W'(1);
              col   <= '0;
              state <= LINE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        VBLANK: begin
          vsync   <= 1'b0;
          hsync   <= 1'b0;
          pixdata <= 8'd0;
          if (cnt == CNT_W'(VB_CYC - 1)) begin
            cnt   <= '0;
            row   <= '0;
            addr  <= '0;
            state <= FRONT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= FRONT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hm01b0_sim.sv
// Bench for hm01b0_sim with a reduced geometry; expected stream computed from
// the frame layout (position within frame -> row/col) against a shadow image.
module tb_hm01b0_sim;

  localparam int W     = 16;
  localparam int H     = 6;
  localparam int HB    = 4;
  localparam int VF    = 3;
  localparam int VBL   = 2;
  localparam int L     = W + HB;
  localparam int FRAME = VF + H * L + VBL * L;

  logic       mclk = 1'b0;
  logic       nreset = 1'b0;
  logic       clock;
  logic [7:0] pixdata;
  logic       hsync;
  logic       vsync;

  logic [7:0] img [W*H];
  int n_tests = 0;
  int n_fail  = 0;

  hm01b0_sim #(
    .WIDTH(W), .HEIGHT(H), .H_BLANK(HB), .V_FRONT(VF), .V_BLANK_LINES(VBL)
  ) dut (
    .mclk(mclk), .nreset(nreset), .clock(clock),
    .pixdata(pixdata), .hsync(hsync), .vsync(vsync)
  );

  always #5 mclk = ~mclk;

  // Expected {clock, vsync, hsync, pixdata} for the t-th cycle after reset release.
  function automatic logic [10:0] model(input int t);
    int p, q, r, c;
    logic vs, hs;
    logic [7:0] d;
    p = t % FRAME;
    vs = 1'b0; hs = 1'b0; d = 8'd0;
    if (p < VF) begin
      vs = 1'b1;
    end else if (p < VF + H * L) begin
      q = p - VF;
      r = q / L;
      c = q % L;
      vs = 1'b1;
      if (c < W) begin
        hs = 1'b1;
        d  = img[r * W + c];
      end
    end
    return {1'b1, vs, hs, d};
  endfunction

  task automatic load_image();
    for (int i = 0; i < W * H; i++) dut.hm01b0_image[i] = img[i];
  endtask

  task automatic randomize_image();
    for (int i = 0; i < W * H; i++) img[i] = 8'($urandom);
    load_image();
  endtask

  task automatic apply_reset();
    @(negedge mclk);
    nreset = 1'b0;
    repeat (2) @(posedge mclk);
  endtask

  task automatic release_reset();
    @(negedge mclk);
    nreset = 1'b1;
  endtask

  task automatic sample(output logic [10:0] a);
    @(negedge mclk);
    a = {clock, vsync, hsync, pixdata};
  endtask

  task automatic test_reset();
    logic [10:0] a;
    int first_v, first_h;
    randomize_image();
    apply_reset();
    @(negedge mclk);
    n_tests++; if (hsync !== 1'b0) begin n_fail++; $display("FAIL reset_hsync got %b want 0", hsync); end
    n_tests++; if (vsync !== 1'b0) begin n_fail++; $display("FAIL reset_vsync got %b want 0", vsync); end
    n_tests++; if (pixdata !== 8'd0) begin n_fail++; $display("FAIL reset_pixdata got %h want 00", pixdata); end
    n_tests++; if (clock !== 1'b0) begin n_fail++; $display("FAIL reset_clock got %b want 0", clock); end
    nreset = 1'b1;
    first_v = -1; first_h = -1;
    for (int k = 0; k < 4 * L; k++) begin
      sample(a);
      if (first_v < 0 && a[9] === 1'b1) first_v = k;
      if (first_h < 0 && a[8] === 1'b1) first_h = k;
    end
    n_tests++; if (first_v !== 0) begin n_fail++; $display("FAIL vsync_rise cycle got %0d want 0", first_v); end
    n_tests++; if (first_h !== VF) begin n_fail++; $display("FAIL hsync_rise cycle got %0d want %0d", first_h, VF); end
  endtask

  task automatic test_pixel_order();
    logic [10:0] a, e;
    int shown = 0;
    for (int i = 0; i < W * H; i++) img[i] = 8'(i);
    load_image();
    apply_reset();
    release_reset();
    for (int t = 0; t < FRAME + 2 * L; t++) begin
      sample(a);
      e = model(t);
      n_tests++;
      if (a !== e) begin
        n_fail++;
        if (shown++ < 10) $display("FAIL pixel_order t=%0d got %h want %h", t, a, e);
      end
    end
  endtask

  task automatic test_line_timing();
    logic [10:0] a;
    logic h, v, ph, pv;
    int hrun, lrun, vrun, vlrun, rises, seen_frames;
    randomize_image();
    apply_reset();
    release_reset();
    ph = 1'b0; pv = 1'b0;
    hrun = 0; lrun = 0; vrun = 0; vlrun = 0; rises = 0; seen_frames = 0;
    for (int k = 0; k < 2 * FRAME + 1; k++) begin
      sample(a);
      h = a[8]; v = a[9];
      if (v && !pv) begin
        if (k > 0) begin
          n_tests++;
          if (vlrun !== VBL * L) begin n_fail++; $display("FAIL vsync_low_len got %0d want %0d", vlrun, VBL * L); end
        end
        vrun = 0; rises = 0;
      end
      if (!v && pv) begin
        seen_frames++;
        n_tests++;
        if (vrun !== VF + H * L) begin n_fail++; $display("FAIL vsync_high_len got %0d want %0d", vrun, VF + H * L); end
        n_tests++;
        if (rises !== H) begin n_fail++; $display("FAIL hsync_pulses got %0d want %0d", rises, H); end
        vlrun = 0;
      end
      if (h && !ph) begin
        if (rises > 0) begin
          n_tests++;
          if (lrun !== HB) begin n_fail++; $display("FAIL hsync_low_len got %0d want %0d", lrun, HB); end
        end
        rises++; hrun = 0;
      end
      if (!h && ph) begin
        n_tests++;
        if (hrun !== W) begin n_fail++; $display("FAIL hsync_high_len got %0d want %0d", hrun, W); end
        lrun = 0;
      end
      if (h) hrun++; else lrun++;
      if (v) vrun++; else vlrun++;
      ph = h; pv = v;
    end
    n_tests++;
    if (seen_frames !== 2) begin n_fail++; $display("FAIL frames_seen got %0d want 2", seen_frames); end
  endtask

  task automatic test_frame_repeat_update();
    logic [10:0] a, e;
    int shown = 0;
    int split, idx;
    randomize_image();
    apply_reset();
    release_reset();
    split = VF + H * L + $urandom_range(0, VBL * L - 2);
    for (int t = 0; t < 2 * FRAME + 2 * L; t++) begin
      if (t == split || t == FRAME + split) begin
        for (int j = 0; j < 8; j++) begin
          idx = $urandom_range(0, W * H - 1);
          img[idx] = 8'($urandom);
          dut.hm01b0_image[idx] = img[idx];
        end
      end
      sample(a);
      e = model(t);
      n_tests++;
      if (a !== e) begin
        n_fail++;
        if (shown++ < 10) $display("FAIL frame_update t=%0d got %h want %h", t, a, e);
      end
    end
  endtask

  task automatic test_mid_line_reset();
    logic [10:0] a, e;
    int shown = 0;
    int target;
    randomize_image();
    apply_reset();
    release_reset();
    target = VF + $urandom_range(1, H - 1) * L + $urandom_range(1, W - 2);
    for (int t = 0; t <= target; t++) begin
      sample(a);
      e = model(t);
      n_tests++;
      if (a !== e) begin
        n_fail++;
        if (shown++ < 10) $display("FAIL pre_reset t=%0d got %h want %h", t, a, e);
      end
    end
    nreset = 1'b0;
    #1;
    n_tests++;
    if ({clock, vsync, hsync, pixdata} !== 11'd0) begin
      n_fail++;
      $display("FAIL async_reset got %h want 000", {clock, vsync, hsync, pixdata});
    end
    repeat (2) @(posedge mclk);
    release_reset();
    for (int t = 0; t < VF + 2 * L; t++) begin
      sample(a);
      e = model(t);
      n_tests++;
      if (a !== e) begin
        n_fail++;
        if (shown++ < 20) $display("FAIL post_reset t=%0d got %h want %h", t, a, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pixel_order();
    test_line_timing();
    test_frame_repeat_update();
    test_mid_line_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
